// File: rtl/mul_pkg.sv
// Shared parameters and FSM encoding for the sequential shift-add multiplier.
package mul_pkg;
    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/adder32.sv
// 32-bit ripple adder with carry in/out; the single adder of the multiplier datapath.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] y,
    output logic        cout
);
    assign {cout, y} = {1'b0, a} + {1'b0, b} + {32'b0, cin};
endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per RUN cycle.
// Optional SEQ_MULTIPLIER_EARLY_EXIT_EN: leave RUN once the remaining multiplier bits are zero.
module seq_multiplier
    import mul_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_reg, lo, lo_nx, lo_fin;
    logic [WIDTH:0]     hi, hi_nx, hi_fin, sum;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   add_y;
    logic               add_cout;
    logic               accept, last;

    assign accept = start && (state == IDLE || state == DONE);

    adder32 u_add (
        .a    (hi[WIDTH-1:0]),
        .b    (a_reg),
        .cin  (1'b0),
        .y    (add_y),
        .cout (add_cout)
    );

    always_comb begin
        sum            = lo[0] ? {add_cout, add_y} : hi;
        {hi_nx, lo_nx} = {sum, lo} >> 1;
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
        // lo_nx[30-cnt:0] holds the multiplier bits not yet consumed.
        last = (cnt == CNT_W'(ITERATIONS - 1)) ||
               ((lo_nx & ({1'b0, {(WIDTH-1){1'b1}}} >> cnt)) == '0);
        // Skipped iterations would only shift, so apply them in one go.
        {hi_fin, lo_fin} = {hi_nx, lo_nx} >> (~cnt);
`else
        last             = (cnt == CNT_W'(ITERATIONS - 1));
        {hi_fin, lo_fin} = {hi_nx, lo_nx};
`endif
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Status outputs are registered, so they trail the state register by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_reg   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
        end else begin
            busy <= (state == RUN);
            done <= (state == DONE);
            if (state == DONE) product <= {hi[WIDTH-1:0], lo};
            if (accept) begin
                a_reg <= a;
                hi    <= '0;
                lo    <= b;
                cnt   <= '0;
            end else if (state == RUN) begin
                hi <= last ? hi_fin : hi_nx;
                lo <= last ? lo_fin : lo_nx;
                if (!last) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: stimulus pushes expected ops, a negedge monitor checks outputs.
module tb_seq_multiplier;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [63:0] product;

    typedef struct {
        logic [63:0] prod;
        int          k;
        int          n;
    } op_t;

    op_t         sb[$];
    int          cyc = 0;
    int          free_edge = 0;
    logic [63:0] exp_prod = '0;
    int          n_chk = 0, n_fail = 0;

    seq_multiplier dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int run_len(logic [31:0] m);
`ifdef SEQ_MULTIPLIER_EARLY_EXIT_EN
        for (int i = 31; i >= 0; i--) if (m[i]) return i + 1;
        return 1;
`else
        return 32;
`endif
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, after the edge numbered cyc.
    always @(negedge clk) begin
        logic exp_done, exp_busy;
        if (!reset) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
            if (sb.size() > 0) begin
                exp_busy = (cyc >= sb[0].k + 1) && (cyc <= sb[0].k + sb[0].n);
                if (cyc == sb[0].k + sb[0].n + 1) begin
                    exp_done = 1'b1;
                    exp_prod = sb[0].prod;
                    void'(sb.pop_front());
                end
            end
            chk("done", 64'(done), 64'(exp_done));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("product", product, exp_prod);
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drive start for one edge; the model decides whether the DUT will take it.
    task automatic issue(logic [31:0] x, logic [31:0] y);
        int  k;
        op_t op;
        start = 1'b1;
        a = x;
        b = y;
        k = cyc + 1;
        if (k >= free_edge) begin
            op.prod = {32'b0, x} * {32'b0, y};
            op.k = k;
            op.n = run_len(y);
            sb.push_back(op);
            free_edge = k + op.n + 1;
        end
        step(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        exp_prod = '0;
        free_edge = 0;
        step(1);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            step(1);
            guard++;
        end
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: %0d ops outstanding, expected 0", sb.size());
            sb.delete();
        end
        step(2);
    endtask

    initial begin
        step(2);
        do_reset();
        step(1);

        issue(32'd3, 32'd5);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle();
        issue(32'd0, 32'h1234_5678);
        wait_idle();

        // Start during RUN must be ignored.
        issue(32'd5, 32'd9);
        step(9);
        issue(32'd7, 32'd7);
        wait_idle();

        // Reset mid-run, then a fresh op straight after release.
        issue(32'd11, 32'd13);
        step(19);
        do_reset();
        issue(32'd9, 32'd9);
        wait_idle();

        // Start held high across DONE: back-to-back ops.
        for (int i = 0; i < 70; i++) issue(32'd2, 32'd6);
        wait_idle();

        issue(32'h1234, 32'd1);
        wait_idle();
        issue(32'h8000_0001, 32'h8000_0000);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = (i % 4 == 0) ? ($urandom & 32'h0000_00FF) : $urandom;
            issue(x, y);
            if ($urandom_range(0, 2) == 0) wait_idle();
            else step($urandom_range(0, 40));
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: start  input  1  request a new multiply; sampled on rising clk.
REQ-004 SHALL have: a  input  32  multiplicand, unsigned; captured only when start is accepted.
REQ-005 SHALL have: b  input  32  multiplier, unsigned; captured only when start is accepted.
REQ-006 SHALL have: busy  output  1  high while an operation is in RUN.
REQ-007 SHALL have: done  output  1  single-cycle pulse; product valid.
REQ-008 SHALL have: product  output  64  a*b, held until the next accepted start.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-010 SHALL accept start only in IDLE or DONE; start in RUN is ignored with no state change.
REQ-011 On accept: register a, set hi[32:0]=0, lo=b, iteration counter=0, next state RUN.
REQ-012 Each RUN cycle: if lo[0]=1, sum={cout,y} of shared adder on (hi[31:0], a_reg, cin=0); else sum=hi; then {hi,lo} <= {sum,lo} >> 1 (33+32 bits, MSB filled from sum[32]).
REQ-013 SHALL execute exactly 32 RUN cycles (counter 0..31), then enter DONE.
REQ-014 Latency: start sampled at edge k -> done=1 in the cycle after edge k+33; busy=1 in the 32 cycles after edges k+1..k+32.
REQ-015 In DONE: done=1 for exactly one cycle, product={hi[31:0],lo}; next state IDLE unless start accepted (then RUN, back-to-back, no idle cycle).
REQ-016 product SHALL be registered and change only on entry to DONE or on reset.
REQ-017 Counter SHALL be 5 bits; terminal detection on value 31, no wrap-around into a 33rd iteration.
REQ-018 All arithmetic unsigned; 0xFFFFFFFF*0xFFFFFFFF SHALL yield 0xFFFFFFFE00000001 without overflow.

Reset
REQ-019 reset=1 at any edge, including mid-RUN or with start=1, SHALL force IDLE, busy=0, done=0, product=0, counter=0, hi=0, lo=0; reset takes priority over start.
REQ-020 First start is accepted on the first edge after reset deasserts.

Configuration
REQ-021 Macro SEQ_MULTIPLIER_EARLY_EXIT_EN: when defined, RUN SHALL exit to DONE after the iteration in which the shifted lo upper (31-counter) multiplier bits are all zero, with product right-aligned by a final barrel shift of lo/hi by the skipped count; latency varies 1..32 RUN cycles.
REQ-022 Without SEQ_MULTIPLIER_EARLY_EXIT_EN, latency SHALL be fixed at 32 RUN cycles per REQ-014 regardless of operands.

Structure
REQ-023 Package mul_pkg SHALL hold WIDTH=32, ITERATIONS=32, counter width, and the state enumeration (IDLE, RUN, DONE).
REQ-024 SHALL instantiate exactly one existing adder32 (ports a, b, cin, y, cout) as the only adder; no "+" operator on the datapath besides the 5-bit counter.

Verification
REQ-025 a=3, b=5, start one cycle -> done at edge k+33 cycle, product=15, busy high 32 cycles.
REQ-026 a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; a=0, b=0x12345678 -> product=0.
REQ-027 start pulsed again at RUN cycle 10 with a=7, b=7 -> ignored; first result returned; no extra done.
REQ-028 reset asserted at RUN cycle 20 -> next cycle IDLE, busy=0, product=0; new start 9*9 -> 81 with full latency.
REQ-029 start held high through DONE with a=2, b=6 -> DONE lasts one cycle, second op begins immediately, product 12 at its done.
REQ-030 With SEQ_MULTIPLIER_EARLY_EXIT_EN: a=0x1234, b=1 -> done after 1 RUN cycle, product=0x1234; without macro -> after 32.
